// File: rtl/div_issue_ctrl_if.sv
// Bundle of upstream operand, divider-side and downstream result signals for div_issue_ctrl.
// master = the issue controller, slave = whatever sits on the other side (upstream, divider, sink).
interface div_issue_ctrl_if #(
   parameter int WIDTH = 32
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
   // valid never waits on ready, and payload is held stable while valid && !ready.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_dividend;
   logic [WIDTH-1:0] in_divisor;

   logic [WIDTH-1:0] div_dividend;
   logic [WIDTH-1:0] div_divisor;
   logic             div_start;
   logic [WIDTH-1:0] div_quotient;
   logic [WIDTH-1:0] div_remainder;
   logic             div_error;
   logic             div_done;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_quotient;
   logic [WIDTH-1:0] out_remainder;
   logic             out_error;
   logic             out_timeout;

   modport master (
      input  in_valid, in_dividend, in_divisor,
      input  div_quotient, div_remainder, div_error, div_done,
      input  out_ready,
      output in_ready,
      output div_dividend, div_divisor, div_start,
      output out_valid, out_quotient, out_remainder, out_error, out_timeout
   );

   modport slave (
      output in_valid, in_dividend, in_divisor,
      output div_quotient, div_remainder, div_error, div_done,
      output out_ready,
      input  in_ready,
      input  div_dividend, div_divisor, div_start,
      input  out_valid, out_quotient, out_remainder, out_error, out_timeout
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// Queues operand pairs, issues them one at a time to a multi-cycle divider and returns
// the captured results in push order, with a watchdog that fails a job whose divider never answers.
module div_issue_ctrl #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   div_issue_ctrl_if.master             bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [1:0]                   dbg_state
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_e;

   state_e           state_q, state_d;

   logic [WIDTH-1:0] fifo_dvd_q [DEPTH];
   logic [WIDTH-1:0] fifo_dvd_d [DEPTH];
   logic [WIDTH-1:0] fifo_dvs_q [DEPTH];
   logic [WIDTH-1:0] fifo_dvs_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [TW-1:0]    wdog_q, wdog_d;
   logic [WIDTH-1:0] div_dvd_q, div_dvd_d;
   logic [WIDTH-1:0] div_dvs_q, div_dvs_d;
   logic [WIDTH-1:0] out_quo_q, out_quo_d;
   logic [WIDTH-1:0] out_rem_q, out_rem_d;
   logic             out_valid_q, out_valid_d;
   logic             out_error_q, out_error_d;
   logic             out_timeout_q, out_timeout_d;

   logic             push;
   logic             pop;
   logic             in_ready;

   // Ready looks only at the registered count, so a pop in the same cycle never frees a full slot.
   assign in_ready = !reset && (count_q < DEPTH_C);
   assign push     = bus.in_valid && in_ready;

   always_comb begin
      fifo_dvd_d = fifo_dvd_q;
      fifo_dvs_d = fifo_dvs_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         fifo_dvd_d[wr_ptr_q] = bus.in_dividend;
         fifo_dvs_d[wr_ptr_q] = bus.in_divisor;
         wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      div_dvd_d     = div_dvd_q;
      div_dvs_d     = div_dvs_q;
      out_quo_d     = out_quo_q;
      out_rem_d     = out_rem_q;
      out_valid_d   = out_valid_q;
      out_error_d   = out_error_q;
      out_timeout_d = out_timeout_q;
      pop           = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               // Operands are latched here and stay put until the next job is issued.
               div_dvd_d = fifo_dvd_q[rd_ptr_q];
               div_dvs_d = fifo_dvs_q[rd_ptr_q];
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            pop     = 1'b1;
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.div_done) begin
               out_quo_d     = bus.div_quotient;
               out_rem_d     = bus.div_remainder;
               out_error_d   = bus.div_error;
               out_timeout_d = 1'b0;
               out_valid_d   = 1'b1;
               state_d       = HOLD;
            end else if (wdog_q == WDOG_LAST) begin
               out_quo_d     = '0;
               out_rem_d     = '0;
               out_error_d   = 1'b1;
               out_timeout_d = 1'b1;
               out_valid_d   = 1'b1;
               state_d       = HOLD;
            end else begin
               wdog_d = wdog_q + TW'(1);
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         wdog_q        <= '0;
         div_dvd_q     <= '0;
         div_dvs_q     <= '0;
         out_quo_q     <= '0;
         out_rem_q     <= '0;
         out_valid_q   <= 1'b0;
         out_error_q   <= 1'b0;
         out_timeout_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_dvd_q[i] <= '0;
            fifo_dvs_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         wdog_q        <= wdog_d;
         div_dvd_q     <= div_dvd_d;
         div_dvs_q     <= div_dvs_d;
         out_quo_q     <= out_quo_d;
         out_rem_q     <= out_rem_d;
         out_valid_q   <= out_valid_d;
         out_error_q   <= out_error_d;
         out_timeout_q <= out_timeout_d;
         fifo_dvd_q    <= fifo_dvd_d;
         fifo_dvs_q    <= fifo_dvs_d;
      end
   end

   assign bus.in_ready      = in_ready;
   assign bus.div_start     = (state_q == ISSUE);
   assign bus.div_dividend  = div_dvd_q;
   assign bus.div_divisor   = div_dvs_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_quotient  = out_quo_q;
   assign bus.out_remainder = out_rem_q;
   assign bus.out_error     = out_error_q;
   assign bus.out_timeout   = out_timeout_q;
   assign count             = count_q;
   assign dbg_state         = state_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: vector table, hand-built corner sequences and a randomized run
// checked by an in-order scoreboard; a simple divider model answers each start pulse.
`timescale 1ns/1ps
module tb_div_issue_ctrl;
   localparam int WIDTH   = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int CW      = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] count;
   logic [1:0]    dbg_state;

   div_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

   div_issue_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.master), .count(count), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] dvd;
      logic [WIDTH-1:0] dvs;
      int               lat;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             err;
   } vec_t;

   vec_t             vecs[7];
   logic [2*WIDTH-1:0] exp_q[$];
   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               starts = 0;
   int               start_cyc = 0;
   int               push_cyc = 0;
   bit               pushed = 0;
   bit               sb_en = 0;
   bit               mute = 0;
   bit               rand_lat = 0;
   int               lat = 3;
   bit               pend = 0;
   int               cnt = 0;
   logic [WIDTH-1:0] m_dvd, m_dvs;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {error, quotient, remainder}; a zero divisor answers all-ones / dividend with error set.
   function automatic logic [2*WIDTH:0] ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (b == 0) return {1'b1, {WIDTH{1'b1}}, a};
      return {1'b0, a / b, a % b};
   endfunction

   // One clock: note handshakes about to happen, let the edge pass, then advance the divider model.
   task automatic tick();
      logic [2*WIDTH-1:0] e;
      logic [2*WIDTH:0]   r;
      pushed = 0;
      if (bus.in_valid && bus.in_ready) begin
         pushed   = 1;
         push_cyc = cyc;
         if (sb_en) exp_q.push_back({bus.in_dividend, bus.in_divisor});
      end
      if (bus.div_start) begin
         starts++;
         start_cyc = cyc;
         if (!mute) begin
            pend  = 1;
            cnt   = rand_lat ? int'($urandom_range(1, 40)) : lat;
            m_dvd = bus.div_dividend;
            m_dvs = bus.div_divisor;
         end
      end
      if (sb_en && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_spurious_out_valid", 64'(bus.out_valid), 0);
         end else begin
            e = exp_q.pop_front();
            r = ref_div(e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
            chk("sb_quotient", 64'(bus.out_quotient), 64'(r[2*WIDTH-1:WIDTH]));
            chk("sb_remainder", 64'(bus.out_remainder), 64'(r[WIDTH-1:0]));
            chk("sb_err_timeout", {62'd0, bus.out_error, bus.out_timeout}, {62'd0, r[2*WIDTH], 1'b0});
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      bus.div_done = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            pend              = 0;
            r                 = ref_div(m_dvd, m_dvs);
            bus.div_done      = 1'b1;
            bus.div_error     = r[2*WIDTH];
            bus.div_quotient  = r[2*WIDTH-1:WIDTH];
            bus.div_remainder = r[WIDTH-1:0];
         end
      end
   endtask

   task automatic push_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int budget, output bit ok);
      bus.in_valid    = 1'b1;
      bus.in_dividend = a;
      bus.in_divisor  = b;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = pushed;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int budget, input string name);
      int i;
      i = 0;
      while (!bus.out_valid && i < budget) begin
         tick();
         i++;
      end
      chk({name, "_out_valid"}, 64'(bus.out_valid), 1);
   endtask

   task automatic take_out();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bit ok;
      int s0;
      int seen;
      int sent;
      int guard;

      vecs[0] = '{100, 7, 33, 14, 2, 1'b0};
      vecs[1] = '{5, 0, 4, 32'hFFFF_FFFF, 5, 1'b1};
      vecs[2] = '{0, 3, 1, 0, 0, 1'b0};
      vecs[3] = '{255, 16, 2, 15, 15, 1'b0};
      vecs[4] = '{32'hFFFF_FFFF, 1, 6, 32'hFFFF_FFFF, 0, 1'b0};
      vecs[5] = '{7, 9, 3, 0, 7, 1'b0};
      vecs[6] = '{1000, 10, 12, 100, 0, 1'b0};

      bus.in_valid      = 1'b0;
      bus.in_dividend   = '0;
      bus.in_divisor    = '0;
      bus.div_quotient  = '0;
      bus.div_remainder = '0;
      bus.div_error     = 1'b0;
      bus.div_done      = 1'b0;
      bus.out_ready     = 1'b0;

      // Power-on reset
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 0);
      chk("rst_count", 64'(count), 0);
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_div_start", 64'(bus.div_start), 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", 64'(bus.in_ready), 1);

      // Vector table: one job at a time, result checked before the downstream handshake
      foreach (vecs[i]) begin
         s0  = starts;
         lat = vecs[i].lat;
         push_job(vecs[i].dvd, vecs[i].dvs, 5, ok);
         chk("tbl_push", 64'(ok), 1);
         wait_out(TIMEOUT + 20, "tbl");
         chk("tbl_start_latency", 64'(start_cyc - push_cyc), 2);
         chk("tbl_done_latency", 64'(cyc - start_cyc), 64'(vecs[i].lat + 1));
         chk("tbl_start_pulses", 64'(starts - s0), 1);
         chk("tbl_quotient", 64'(bus.out_quotient), 64'(vecs[i].q));
         chk("tbl_remainder", 64'(bus.out_remainder), 64'(vecs[i].r));
         chk("tbl_err_timeout", {62'd0, bus.out_error, bus.out_timeout}, {62'd0, vecs[i].err, 1'b0});
         take_out();
         chk("tbl_out_valid_clear", 64'(bus.out_valid), 0);
      end

      // Downstream stall: results hold and the queued job is not issued until the handshake
      lat = 4;
      push_job(200, 3, 5, ok);
      push_job(9, 2, 5, ok);
      wait_out(40, "hold_a");
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", 64'(bus.out_valid), 1);
         chk("hold_quotient", 64'(bus.out_quotient), 66);
         chk("hold_remainder", 64'(bus.out_remainder), 2);
      end
      chk("hold_no_start", 64'(starts - s0), 0);
      chk("hold_count", 64'(count), 1);
      take_out();
      wait_out(40, "hold_b");
      chk("hold_b_start", 64'(starts - s0), 1);
      chk("hold_b_quotient", 64'(bus.out_quotient), 4);
      chk("hold_b_remainder", 64'(bus.out_remainder), 1);
      take_out();

      // Watchdog: divider never answers
      mute = 1;
      push_job(77, 7, 5, ok);
      wait_out(TIMEOUT + 20, "to");
      chk("to_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
      chk("to_err_timeout", {62'd0, bus.out_error, bus.out_timeout}, 64'b11);
      chk("to_quotient", 64'(bus.out_quotient), 0);
      chk("to_remainder", 64'(bus.out_remainder), 0);
      take_out();
      mute = 0;

      // Backpressure: fill the queue behind a held result, then drain in order
      sb_en = 1;
      exp_q.delete();
      lat = 2;
      for (int j = 0; j < 5; j++) begin
         push_job(32'(100 + 13 * j), 32'(j + 3), 8, ok);
         chk("bp_push", 64'(ok), 1);
      end
      bus.in_valid    = 1'b1;
      bus.in_dividend = 500;
      bus.in_divisor  = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pushed) seen++;
      end
      chk("bp_sixth_stalls", 64'(seen), 0);
      chk("bp_count_full", 64'(count), 64'(DEPTH));
      chk("bp_in_ready_low", 64'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      guard = 0;
      while (bus.in_valid && guard < 200) begin
         tick();
         if (pushed) bus.in_valid = 1'b0;
         guard++;
      end
      chk("bp_sixth_accepted", 64'(bus.in_valid), 0);
      guard = 0;
      while (exp_q.size() != 0 && guard < 400) begin
         tick();
         guard++;
      end
      chk("bp_drained", 64'(exp_q.size()), 0);

      // Randomized traffic against the scoreboard
      rand_lat = 1;
      sent  = 0;
      guard = 0;
      while ((sent < 40 || exp_q.size() != 0) && guard < 20000) begin
         if (!bus.in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = $urandom;
            case ($urandom_range(0, 3))
               0:       bus.in_divisor = 0;
               1:       bus.in_divisor = $urandom;
               default: bus.in_divisor = $urandom_range(1, 1000);
            endcase
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
         if (pushed) begin
            sent++;
            bus.in_valid = 1'b0;
         end
      end
      chk("rand_sent", 64'(sent), 40);
      chk("rand_drained", 64'(exp_q.size()), 0);
      rand_lat = 0;
      sb_en    = 0;

      // Reset while waiting on the divider with two jobs queued
      bus.out_ready = 1'b1;
      lat = 30;
      push_job(50, 5, 5, ok);
      push_job(60, 6, 5, ok);
      push_job(70, 7, 5, ok);
      tick();
      tick();
      chk("mid_count_before", 64'(count), 2);
      reset = 1'b1;
      #1;
      chk("mid_count", 64'(count), 0);
      chk("mid_in_ready", 64'(bus.in_ready), 0);
      chk("mid_div_start", 64'(bus.div_start), 0);
      chk("mid_div_operands", {bus.div_dividend, bus.div_divisor}, 0);
      chk("mid_out_data", {bus.out_quotient, bus.out_remainder}, 0);
      chk("mid_out_flags", {61'd0, bus.out_valid, bus.out_error, bus.out_timeout}, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rel_in_ready", 64'(bus.in_ready), 1);
      s0   = starts;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      chk("mid_no_out_valid", 64'(seen), 0);
      chk("mid_no_start", 64'(starts - s0), 0);
      chk("mid_count_after", 64'(count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
